// File: rtl/serv_alu_seq.sv
// Pass sequencer for the bit-serial ALU: walks an optional INIT pass, an
// optional shift-wait and a RUN pass, emitting the per-bit ALU strobes.
module serv_alu_seq #(
  parameter  int WIDTH = 32,
  localparam int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             i_rst_n,
  input  logic             i_req,
  input  logic             i_two_stage,
  input  logic             i_shift,
  input  logic             i_flush,
  input  logic             i_sh_done,
  output logic             o_busy,
  output logic             o_en,
  output logic             o_init,
  output logic             o_cnt_done,
  output logic             o_shamt_en,
  output logic             o_rd_en,
  output logic             o_ack,
  output logic [CNT_W-1:0] o_cnt
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_INIT,
    S_SHWAIT,
    S_RUN
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(WIDTH - 1);
  // The shift amount occupies the low five operand bits.
  localparam logic [CNT_W-1:0] SHAMT_BITS = CNT_W'(5);

  state_t           state, state_next;
  logic [CNT_W-1:0] cnt, cnt_next;
  logic             shift_q, shift_next;
  logic             last_bit;

  assign last_bit = (cnt == CNT_LAST);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of process ordering.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state   <= S_IDLE;
      cnt     <= '0;
      shift_q <= 1'b0;
    end else begin
      state   <= state_next;
      cnt     <= cnt_next;
      shift_q <= shift_next;
    end
  end

  // NOTE: every signal driven here gets a default first so no path through
  // the case statement can leave it unassigned and infer a latch.
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    shift_next = shift_q;
    unique case (state)
      S_IDLE: begin
        if (i_req) begin
          shift_next = i_shift;
          state_next = (i_two_stage || i_shift) ? S_INIT : S_RUN;
          cnt_next   = '0;
        end
      end
      S_INIT: begin
        cnt_next = cnt + CNT_W'(1);
        if (last_bit) state_next = shift_q ? S_SHWAIT : S_RUN;
      end
      S_SHWAIT: begin
        cnt_next = '0;
        if (i_sh_done) state_next = S_RUN;
      end
      S_RUN: begin
        cnt_next = cnt + CNT_W'(1);
        if (last_bit) state_next = S_IDLE;
      end
      default: state_next = S_IDLE;
    endcase
    // Abort overrides everything, including an accept in IDLE.
    if (i_flush) begin
      state_next = S_IDLE;
      cnt_next   = '0;
    end
  end

  assign o_busy     = (state != S_IDLE);
  assign o_init     = (state == S_INIT);
  assign o_rd_en    = (state == S_RUN);
  assign o_en       = o_init || o_rd_en;
  assign o_cnt_done = o_en && last_bit;
  assign o_shamt_en = o_init && shift_q && (cnt < SHAMT_BITS);
  assign o_ack      = o_rd_en && last_bit && !i_flush;
  assign o_cnt      = cnt;

endmodule

// File: tb/tb_serv_alu_seq.sv
// Self-checking bench for serv_alu_seq: a timeline model (cycles since
// accept) predicts every output each cycle, plus literal latency checks.
module tb_serv_alu_seq;

  localparam int W  = 32;
  localparam int CW = $clog2(W);

  logic          clk = 1'b0;
  logic          i_rst_n = 1'b0;
  logic          i_req = 1'b0, i_two_stage = 1'b0, i_shift = 1'b0;
  logic          i_flush = 1'b0, i_sh_done = 1'b0;
  logic          o_busy, o_en, o_init, o_cnt_done, o_shamt_en, o_rd_en, o_ack;
  logic [CW-1:0] o_cnt;

  int vectors = 0;
  int miscompares = 0;

  serv_alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_req(i_req), .i_two_stage(i_two_stage),
    .i_shift(i_shift), .i_flush(i_flush), .i_sh_done(i_sh_done),
    .o_busy(o_busy), .o_en(o_en), .o_init(o_init), .o_cnt_done(o_cnt_done),
    .o_shamt_en(o_shamt_en), .o_rd_en(o_rd_en), .o_ack(o_ack), .o_cnt(o_cnt)
  );

  always #5 clk = ~clk;

  wire [11:0] dut_vec = {o_busy, o_en, o_init, o_cnt_done, o_shamt_en,
                         o_rd_en, o_ack, o_cnt};

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // Reference model: an op is a timeline indexed by t (cycle 1 = first cycle
  // after accept). INIT covers t=1..W, RUN starts at run_start.
  int m_busy = 0, m_t = 0, m_two = 0, m_sh = 0, m_rs = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (!i_rst_n) begin
        m_busy = 0;
        check("model_rst", {20'd0, dut_vec}, 32'd0);
      end else begin
        int phase, idx;
        logic [11:0] exp_vec;
        logic e_en, e_init, e_done, e_shamt, e_rd, e_ack;
        int e_cnt;
        phase = 0;
        if (m_busy != 0) begin
          if (m_two != 0 && m_t <= W) phase = 1;
          else if (m_rs == 0 || m_t < m_rs) phase = 2;
          else phase = 3;
        end
        {e_en, e_init, e_done, e_shamt, e_rd, e_ack} = '0;
        e_cnt = 0;
        if (phase == 1) begin
          e_en = 1; e_init = 1; e_cnt = m_t - 1;
          e_done = (m_t == W);
          e_shamt = (m_sh != 0) && (m_t <= 5);
        end else if (phase == 3) begin
          idx = m_t - m_rs;
          e_en = 1; e_rd = 1; e_cnt = idx;
          e_done = (idx == W - 1);
          e_ack = e_done && !i_flush;
        end
        exp_vec = {(m_busy != 0), e_en, e_init, e_done, e_shamt, e_rd, e_ack,
                   CW'(e_cnt)};
        check("cycle_outputs", {20'd0, dut_vec}, {20'd0, exp_vec});

        if (i_flush) begin
          m_busy = 0;
        end else if (m_busy == 0) begin
          if (i_req) begin
            m_busy = 1; m_t = 1;
            m_sh  = int'(i_shift);
            m_two = int'(i_two_stage | i_shift);
            m_rs  = (m_two == 0) ? 1 : ((m_sh != 0) ? 0 : W + 1);
          end
        end else begin
          if (phase == 2 && i_sh_done) m_rs = m_t + 1;
          if (phase == 3 && (m_t - m_rs) == W - 1) m_busy = 0;
          m_t++;
        end
      end
    end
  end

  // Called at posedge+1 of the accept cycle (cycle 0).
  task automatic run_op(input logic two, input logic sh, input int sh_at,
                        input int exp_lat, input int exp_shamt,
                        input string name);
    int lat, nsh;
    lat = -1; nsh = 0;
    i_req = 1; i_two_stage = two; i_shift = sh;
    @(posedge clk); #1;
    i_req = 0; i_two_stage = ~two; i_shift = ~sh;
    for (int k = 1; k <= 200; k++) begin
      if (sh_at > 0 && k >= sh_at) i_sh_done = 1;
      @(negedge clk);
      if (o_shamt_en) nsh++;
      if (o_ack) begin lat = k; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    i_sh_done = 0; i_two_stage = 0; i_shift = 0;
    check({name, "_ack_cycle"}, lat, exp_lat);
    check({name, "_shamt_cycles"}, nsh, exp_shamt);
    @(negedge clk);
    check({name, "_busy_after"}, {31'd0, o_busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic flush_op(input int at, input logic exp_done,
                          input string name);
    i_req = 1;
    @(posedge clk); #1;
    i_req = 0;
    for (int k = 1; k < at; k++) begin
      @(posedge clk); #1;
    end
    i_flush = 1;
    @(negedge clk);
    check({name, "_ack"}, {31'd0, o_ack}, 32'd0);
    check({name, "_cnt_done"}, {31'd0, o_cnt_done}, {31'd0, exp_done});
    @(posedge clk); #1;
    i_flush = 0;
    @(negedge clk);
    check({name, "_busy"}, {31'd0, o_busy}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    int a1, a2;
    #2;
    check("reset_state", {20'd0, dut_vec}, 32'd0);
    #10 i_rst_n = 1;
    @(posedge clk); #1;

    run_op(0, 0, 0, 32, 0, "add");
    run_op(1, 0, 0, 64, 0, "slt");
    run_op(0, 1, 40, 72, 5, "sll_wait");
    run_op(0, 1, 1, 65, 5, "sll_tied");

    flush_op(10, 1'b0, "flush_mid");
    flush_op(32, 1'b1, "flush_last");
    i_req = 1; i_flush = 1;
    @(posedge clk); #1;
    i_req = 0; i_flush = 0;
    @(negedge clk);
    check("flush_req_idle", {31'd0, o_busy}, 32'd0);
    @(posedge clk); #1;

    // Asynchronous reset in the middle of INIT at bit 17.
    i_req = 1; i_two_stage = 1;
    @(posedge clk); #1;
    i_req = 0; i_two_stage = 0;
    repeat (17) begin @(posedge clk); #1; end
    check("pre_reset_cnt", {27'd0, o_cnt}, 32'd17);
    #2 i_rst_n = 0;
    #1 check("async_reset", {20'd0, dut_vec}, 32'd0);
    @(posedge clk); #3 i_rst_n = 1;
    @(posedge clk); #1;
    run_op(0, 0, 0, 32, 0, "add_after_rst");

    // Back-to-back with request held high.
    a1 = -1; a2 = -1;
    i_req = 1;
    @(posedge clk); #1;
    for (int k = 1; k <= 150; k++) begin
      if (k == 34) i_req = 0;
      @(negedge clk);
      if (o_ack) begin
        if (a1 < 0) a1 = k;
        else if (a2 < 0) a2 = k;
      end
      if (a2 >= 0) break;
      @(posedge clk); #1;
    end
    i_req = 0;
    @(posedge clk); #1;
    check("b2b_first_ack", a1, 32);
    check("b2b_second_ack", a2, 65);

    // Randomized traffic, checked every cycle by the model.
    for (int n = 0; n < 4000; n++) begin
      i_req       = 1'($urandom_range(0, 1));
      i_two_stage = 1'($urandom_range(0, 1));
      i_shift     = ($urandom_range(0, 2) == 0);
      i_flush     = ($urandom_range(0, 90) == 0);
      i_sh_done   = ($urandom_range(0, 3) == 0);
      @(posedge clk); #1;
    end
    {i_req, i_two_stage, i_shift, i_flush, i_sh_done} = '0;
    repeat (4) begin @(posedge clk); #1; end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
